// File: rtl/mul_seq_arb_if.sv
// mul_seq_arb_if
//   Bundles the two requester ports, the shared-multiplier operand/product
//   lines and the response port of mul_seq_arb.
//   slave  : the sequencer side (drives readys, multiplier operands, response)
//   master : the environment side (requesters, multiplier, response consumer)
interface mul_seq_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [7:0]  mul_x;
  logic [3:0]  mul_y;
  logic [11:0] mul_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_p;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_z, rsp_ready,
    output req0_ready, req1_ready,
    output mul_x, mul_y,
    output rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_z, rsp_ready,
    input  req0_ready, req1_ready,
    input  mul_x, mul_y,
    input  rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mul_seq_arb.sv
// mul_seq_arb
//   Two-requester sequencer producing signed 8x8 products by making two
//   passes (low nibble, then high nibble of b) through a shared combinational
//   signed 8x4 multiplier.
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mul_seq_arb_if.slave
//            req0_* / req1_*   valid/ready request ports with operands a, b
//            mul_x / mul_y     operands to the shared multiplier
//            mul_z             signed 12-bit product back from the multiplier
//            rsp_*             registered response with requester id
// Parameter
//   PRIO_MODE : 0 round-robin, 1 fixed priority (req0 wins)
module mul_seq_arb #(
  parameter bit PRIO_MODE = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  mul_seq_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             r_state;
  logic               r_ptr;
  logic signed [7:0]  r_a;
  logic signed [7:0]  r_b;
  logic               r_id;
  logic signed [15:0] r_acc;
  logic signed [15:0] r_rsp_p;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [7:0]         r_mul_x;
  logic [3:0]         r_mul_y;

  logic               w_gnt;
  logic               w_accept;
  logic [7:0]         w_sel_a;
  logic [7:0]         w_sel_b;

  // Low pass: the multiplier treats b[3:0] as signed, so when b[3] is set
  // the product is short by a*16; add it back to get a * unsigned(b[3:0]).
  function automatic logic signed [15:0] f_lo_acc(
    input logic signed [11:0] z,
    input logic signed [7:0]  a,
    input logic               b3
  );
    logic signed [15:0] corr;
    corr = b3 ? ({{8{a[7]}}, a} << 4) : 16'sd0;
    return {{4{z[11]}}, z} + corr;
  endfunction

  // High pass: b[7:4] is the true signed upper nibble, so its partial
  // product is added at weight 16 with no further correction.
  function automatic logic signed [15:0] f_hi_sum(
    input logic signed [15:0] acc,
    input logic signed [11:0] z
  );
    return acc + ({{4{z[11]}}, z} << 4);
  endfunction

  // Grant: a lone valid always wins; on contention the pointer (round-robin)
  // or req0 (fixed priority) decides.
  always_comb begin
    w_gnt = 1'b0;
    if (PRIO_MODE)
      w_gnt = !bus.req0_valid;
    else if (bus.req0_valid && bus.req1_valid)
      w_gnt = r_ptr;
    else
      w_gnt = bus.req1_valid;
  end

  assign w_accept = rst_n && (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign w_sel_a  = w_gnt ? bus.req1_a : bus.req0_a;
  assign w_sel_b  = w_gnt ? bus.req1_b : bus.req0_b;

  assign bus.req0_ready = w_accept && !w_gnt;
  assign bus.req1_ready = w_accept &&  w_gnt;
  assign bus.mul_x      = r_mul_x;
  assign bus.mul_y      = r_mul_y;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_p      = r_rsp_p;

  // Operands for the multiplier are registered on the transition into the
  // state that uses them, so mul_x/mul_y are glitch-free and 0 outside LO/HI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_acc       <= '0;
      r_rsp_p     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_gnt;
            r_mul_x <= w_sel_a;
            r_mul_y <= w_sel_b[3:0];
            if (!PRIO_MODE)
              r_ptr <= !w_gnt;
            r_state <= LO;
          end
        end
        LO: begin
          r_acc   <= f_lo_acc(bus.mul_z, r_a, r_b[3]);
          r_mul_y <= r_b[7:4];
          r_state <= HI;
        end
        HI: begin
          r_rsp_p     <= f_hi_sum(r_acc, bus.mul_z);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_mul_x     <= '0;
          r_mul_y     <= '0;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_arb.sv
module tb_mul_seq_arb;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_seq_arb_if u_if();
  mul_seq_arb_if p_if();

  mul_seq_arb #(.PRIO_MODE(1'b0)) dut   (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  mul_seq_arb #(.PRIO_MODE(1'b1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(p_if.slave));

  // Shared signed 8x4 multiplier model
  function automatic logic [11:0] mul_model(input logic [7:0] x, input logic [3:0] y);
    logic signed [11:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
  endfunction
  assign u_if.mul_z = mul_model(u_if.mul_x, u_if.mul_y);
  assign p_if.mul_z = mul_model(p_if.mul_x, p_if.mul_y);

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int p_cnt  = 0;
  logic [16:0] scb[$];
  int gnt_log[$];
  int rsp_cyc[$];
  logic [15:0] exp0, exp1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted request queues its expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.req0_valid && u_if.req0_ready) begin
        scb.push_back({1'b0, exp0});
        gnt_log.push_back(0);
      end
      if (u_if.req1_valid && u_if.req1_ready) begin
        scb.push_back({1'b1, exp1});
        gnt_log.push_back(1);
      end
    end
  end

  // Monitor: pops and compares on every response handshake
  always @(negedge clk) begin
    if (rst_n && u_if.rsp_valid && u_if.rsp_ready) begin
      rsp_cyc.push_back(cyc);
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d p=%h, required no response", u_if.rsp_id, u_if.rsp_p);
      end else begin
        chk("rsp", {15'd0, u_if.rsp_id, u_if.rsp_p}, {15'd0, scb.pop_front()});
      end
    end
  end

  // Fixed-priority instance: only req0 is ever served
  always @(negedge clk) begin
    if (rst_n && p_if.rsp_valid && p_if.rsp_ready) begin
      p_cnt++;
      chk("prio_rsp", {15'd0, p_if.rsp_id, p_if.rsp_p}, {15'd0, 1'b0, 16'h0006});
    end
    if (rst_n && p_if.req1_valid)
      chk("prio_req1_ready", {31'd0, p_if.req1_ready}, 32'd0);
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (scb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", scb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic req_single(input logic id, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] e, input bit lat);
    int n;
    if (!id) begin
      u_if.req0_a = a; u_if.req0_b = b; exp0 = e; u_if.req0_valid = 1'b1;
    end else begin
      u_if.req1_a = a; u_if.req1_b = b; exp1 = e; u_if.req1_valid = 1'b1;
    end
    @(negedge clk);
    n = 1;
    while (!(id ? u_if.req1_ready : u_if.req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
    if (lat) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!u_if.rsp_valid && n < 20);
      chk("latency", n, 3);
      @(posedge clk); #1;
    end
  endtask

  logic [7:0]  t_a [5] = '{8'h07, 8'h80, 8'h7F, 8'hFF, 8'h00};
  logic [7:0]  t_b [5] = '{8'hFD, 8'h80, 8'h80, 8'h08, 8'h80};
  logic [15:0] t_p [5] = '{16'hFFEB, 16'h4000, 16'hC080, 16'hFFF8, 16'h0000};

  initial begin
    int n;
    logic [15:0] cap_p;
    logic        cap_id;
    logic [7:0]  ra, rb;
    logic signed [15:0] sa, sb;

    u_if.req0_valid = 1'b1; u_if.req1_valid = 1'b1;
    u_if.req0_a = 8'h03; u_if.req0_b = 8'h05;
    u_if.req1_a = 8'hFE; u_if.req1_b = 8'h09;
    u_if.rsp_ready = 1'b1;
    p_if.req0_valid = 1'b0; p_if.req1_valid = 1'b0;
    p_if.req0_a = 8'h02; p_if.req0_b = 8'h03;
    p_if.req1_a = 8'h05; p_if.req1_b = 8'h05;
    p_if.rsp_ready = 1'b1;
    exp0 = 16'h000F; exp1 = 16'hFFEE;

    // Reset state, with both requesters asserting valid
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_readys", {30'd0, u_if.req0_ready, u_if.req1_ready}, 0);
    chk("reset_rsp", {15'd0, u_if.rsp_valid, u_if.rsp_id, u_if.rsp_p}, 0);
    chk("reset_mul", {20'd0, u_if.mul_x, u_if.mul_y}, 0);

    // Round-robin alternation with both valid; fixed-priority instance alongside
    @(posedge clk); #1;
    rst_n = 1'b1;
    gnt_log.delete();
    rsp_cyc.delete();
    p_if.req0_valid = 1'b1; p_if.req1_valid = 1'b1;
    fork
      begin
        repeat (30) @(posedge clk);
        #1;
        p_if.req0_valid = 1'b0; p_if.req1_valid = 1'b0;
      end
    join_none
    n = 0;
    while (gnt_log.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    u_if.req0_valid = 1'b0; u_if.req1_valid = 1'b0;
    chk("grant_count", (gnt_log.size() >= 4), 1);
    if (gnt_log.size() >= 4)
      chk("grant_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0101);
    wait_drain();
    chk("rsp_count", (rsp_cyc.size() >= 4), 1);
    for (int i = 1; i < 4; i++)
      if (i < rsp_cyc.size())
        chk("rsp_interval", rsp_cyc[i] - rsp_cyc[i-1], 4);
    repeat (12) @(posedge clk);
    #1;
    chk("prio_served", (p_cnt >= 6), 1);

    // Directed single requests incl. corners, with latency check
    for (int i = 0; i < 5; i++)
      req_single(1'b0, t_a[i], t_b[i], t_p[i], 1'b1);
    req_single(1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b1);
    wait_drain();

    // Backpressure: hold DONE for 5 cycles with req1 waiting
    u_if.rsp_ready = 1'b0;
    req_single(1'b0, 8'h05, 8'h06, 16'h001E, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u_if.rsp_valid && n < 20);
    chk("bp_valid", {31'd0, u_if.rsp_valid}, 1);
    cap_p = u_if.rsp_p;
    cap_id = u_if.rsp_id;
    @(posedge clk); #1;
    u_if.req1_a = 8'h01; u_if.req1_b = 8'h01; exp1 = 16'h0001; u_if.req1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {15'd0, u_if.rsp_valid, u_if.rsp_id, u_if.rsp_p}, {15'd0, 1'b1, cap_id, cap_p});
      chk("bp_readys", {30'd0, u_if.req0_ready, u_if.req1_ready}, 0);
    end
    @(posedge clk); #1;
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_valid", {31'd0, u_if.rsp_valid}, 1);
    @(negedge clk);
    chk("bp_released", {30'd0, u_if.rsp_valid, u_if.req1_ready}, 2'b01);
    @(posedge clk); #1;
    u_if.req1_valid = 1'b0;
    wait_drain();

    // Reset pulsed during HI
    u_if.req0_a = 8'h11; u_if.req0_b = 8'h22; exp0 = 16'h0242; u_if.req0_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u_if.req0_ready && n < 20);
    @(posedge clk); #1;
    u_if.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_pending", scb.size(), 1);
    if (scb.size() != 0) void'(scb.pop_back());
    u_if.req0_a = 8'h03; u_if.req0_b = 8'h05; exp0 = 16'h000F;
    u_if.req1_a = 8'hFE; u_if.req1_b = 8'h09; exp1 = 16'hFFEE;
    u_if.req0_valid = 1'b1; u_if.req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_idle", {3'd0, u_if.rsp_valid, u_if.rsp_p, u_if.mul_x, u_if.mul_y}, 0);
    chk("rst_ptr", {30'd0, u_if.req0_ready, u_if.req1_ready}, 2'b10);
    @(posedge clk); #1;
    u_if.req0_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u_if.req1_ready && n < 20);
    @(posedge clk); #1;
    u_if.req1_valid = 1'b0;
    wait_drain();

    // Random operand sweep through req1 against the signed reference
    for (int i = 0; i < 3000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      sa = $signed(ra);
      sb = $signed(rb);
      req_single(1'b1, ra, rb, sa * sb, 1'b0);
    end
    wait_drain();
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
